// File: rtl/alu_issue_queue.sv
// Command queue in front of the 4-bit ALU: buffers {op, a, b}, issues them one at a time
// from registers, captures the settled ALU result and hands it downstream with valid/ready.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | nothing in flight; pop the FIFO head into alu_* when count > 0
// DRIVE | alu_* stable for one settle cycle; capture alu_res at next edge
// HOLD  | result presented on out_res/out_op until the consumer accepts it
module alu_issue_queue #(
  parameter int DEPTH  = 4,
  parameter int DW     = 4,
  parameter int OPW    = 4,
  parameter int RW     = 8,
  parameter int MAX_OP = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [DW-1:0]  in_a,
  input  logic [DW-1:0]  in_b,
  input  logic [OPW-1:0] in_op,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  output logic [OPW-1:0] alu_op,
  input  logic [RW-1:0]  alu_res,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [RW-1:0]  out_res,
  output logic [OPW-1:0] out_op,
  output logic [2:0]     count,
  output logic           err_illegal
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = 2 * DW + OPW;
  localparam logic [2:0]     FULL_CNT = 3'(DEPTH);
  localparam logic [OPW-1:0] MAX_OP_C = OPW'(MAX_OP);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [1:0]    state;
  logic [EW-1:0] head;
  logic          accept;
  logic          push;
  logic          illegal;
  logic          pop;

  // in_ready is a pure function of the registered count, so a pop never frees a slot early
  assign in_ready = (count < FULL_CNT);
  assign accept   = in_valid & in_ready;
  assign push     = accept & (in_op <= MAX_OP_C);
  assign illegal  = accept & (in_op > MAX_OP_C);
  assign pop      = (count != 3'd0) &
                    ((state == ST_IDLE) | ((state == ST_HOLD) & out_valid & out_ready));
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_op, in_a, in_b};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= 3'd0;
      err_illegal <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      if (illegal) begin
        err_illegal <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      out_res   <= '0;
      out_op    <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            {alu_op, alu_a, alu_b} <= head;
            state                  <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          out_res   <= alu_res;
          out_op    <= alu_op;
          out_valid <= 1'b1;
          state     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            if (pop) begin
              {alu_op, alu_a, alu_b} <= head;
              state                  <= ST_DRIVE;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Self-checking bench for alu_issue_queue: table vectors, directed latency/corner sequences,
// and a randomized stream scored against a queue-based reference model.
module tb_alu_issue_queue;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_a = 4'h0;
  logic [3:0] in_b = 4'h0;
  logic [3:0] in_op = 4'h0;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_op;
  logic [7:0] alu_res;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_res;
  logic [3:0] out_op;
  logic [2:0] count;
  logic       err_illegal;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  bit err_m = 1'b0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] op;
    logic [7:0] exp_res;
    logic       exp_err;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  // ALU stub: result is {op, a ^ b}
  assign alu_res = {alu_op, alu_a ^ alu_b};

  alu_issue_queue #(
    .DEPTH(4), .DW(4), .OPW(4), .RW(8), .MAX_OP(12)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_res(alu_res),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_op(out_op),
    .count(count), .err_illegal(err_illegal)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    tick();
    tick();
    rst   = 1'b0;
    err_m = 1'b0;
    exp_q.delete();
  endtask

  task automatic push_one(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
    int n;
    n = 0;
    in_a = a;
    in_b = b;
    in_op = op;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("push_timeout", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic collect(input string name, input logic [7:0] exp_res);
    int n;
    n = 0;
    out_ready = 1'b0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_res"}, out_res, exp_res);
    tick();
    chk({name, "_hold_valid"}, out_valid, 1);
    chk({name, "_hold_res"}, out_res, exp_res);
    chk({name, "_hold_op"}, out_op, exp_res[7:4]);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic run_stream(input int n_cmds, input bit rand_mode, input int max_cycles);
    int sent, got, legal, cyc;
    bit push_acc, out_acc, pv, pr;
    logic [7:0] pres, e;
    sent = 0; got = 0; legal = 0; cyc = 0;
    while ((sent < n_cmds || exp_q.size() > 0) && cyc < max_cycles) begin
      if (sent < n_cmds && (!rand_mode || $urandom_range(0, 1) == 1)) begin
        in_valid = 1'b1;
        in_a     = 4'($urandom_range(0, 15));
        in_b     = 4'($urandom_range(0, 15));
        in_op    = rand_mode ? 4'($urandom_range(0, 15)) : sent[3:0];
      end else begin
        in_valid = 1'b0;
      end
      out_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'(cyc % 2);
      push_acc = in_valid && in_ready;
      out_acc  = out_valid && out_ready;
      if (out_acc) begin
        if (exp_q.size() == 0) begin
          chk("stream_unexpected_result", out_valid, 0);
        end else begin
          e = exp_q.pop_front();
          chk("stream_res", out_res, e);
          chk("stream_op", out_op, e[7:4]);
          got++;
        end
      end
      if (push_acc) begin
        sent++;
        if (in_op <= 4'd12) begin
          exp_q.push_back({in_op, in_a ^ in_b});
          legal++;
        end else begin
          err_m = 1'b1;
        end
      end
      pv = out_valid;
      pr = out_ready;
      pres = out_res;
      tick();
      cyc++;
      chk("stream_err", err_illegal, err_m);
      chk("stream_in_ready", in_ready, (count < 3'd4));
      if (pv && !pr) begin
        chk("stream_hold_valid", out_valid, 1);
        chk("stream_hold_res", out_res, pres);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("stream_drained", exp_q.size(), 0);
    chk("stream_results", got, legal);
    tick();
    chk("stream_count_end", count, 0);
    chk("stream_valid_end", out_valid, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4'hE, 4'h9, 4'h1, 8'h17, 1'b0};
    vecs[1] = '{4'h3, 4'h5, 4'h0, 8'h06, 1'b0};
    vecs[2] = '{4'hF, 4'hF, 4'hC, 8'hC0, 1'b0};
    vecs[3] = '{4'hA, 4'h5, 4'h7, 8'h7F, 1'b0};
    vecs[4] = '{4'h1, 4'h2, 4'hD, 8'h00, 1'b1};
    vecs[5] = '{4'h0, 4'h0, 4'hF, 8'h00, 1'b1};

    // Scenario 1: reset values and single-command latency
    do_reset();
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_alu", {alu_op, alu_a, alu_b}, 0);
    chk("rst_out", {out_op, out_res}, 0);
    chk("rst_err", err_illegal, 0);
    out_ready = 1'b1;
    in_a = 4'hE; in_b = 4'h9; in_op = 4'h1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t1_e1_count", count, 1);
    chk("t1_e1_valid", out_valid, 0);
    tick();
    chk("t1_e2_alu_a", alu_a, 4'hE);
    chk("t1_e2_alu_b", alu_b, 4'h9);
    chk("t1_e2_alu_op", alu_op, 4'h1);
    chk("t1_e2_valid", out_valid, 0);
    chk("t1_e2_count", count, 0);
    tick();
    chk("t1_e3_valid", out_valid, 1);
    chk("t1_e3_res", out_res, 8'h17);
    chk("t1_e3_op", out_op, 4'h1);
    tick();
    chk("t1_e4_valid", out_valid, 0);
    out_ready = 1'b0;

    // Table vectors, one command at a time
    do_reset();
    for (int i = 0; i < 6; i++) begin
      push_one(vecs[i].a, vecs[i].b, vecs[i].op);
      if (!vecs[i].exp_err) begin
        collect("vec", vecs[i].exp_res);
      end else begin
        chk("vec_illegal_count", count, 0);
      end
      chk("vec_err", err_illegal, vecs[i].exp_err);
    end
    tick();
    chk("vec_no_extra", out_valid, 0);

    // Scenario 2: fill with out_ready low, then drain in order
    do_reset();
    for (int i = 0; i < 5; i++) push_one(4'hE, 4'h9, 4'(i));
    chk("t2_full_count", count, 4);
    chk("t2_full_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_stall_res", out_res, 8'h07);
      chk("t2_stall_ready", in_ready, 0);
    end
    for (int i = 0; i < 5; i++) collect("t2", {4'(i), 4'h7});
    tick();
    chk("t2_end_count", count, 0);
    chk("t2_end_valid", out_valid, 0);

    // Scenario 3: illegal opcode is consumed, flagged sticky, and never issued
    do_reset();
    push_one(4'hE, 4'h9, 4'hD);
    chk("t3_err_set", err_illegal, 1);
    chk("t3_illegal_count", count, 0);
    push_one(4'hE, 4'h9, 4'h2);
    chk("t3_count", count, 1);
    collect("t3", 8'h27);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_no_extra", out_valid, 0);
      chk("t3_err_sticky", err_illegal, 1);
    end

    // Scenario 4: ten commands across the pointer wrap, out_ready toggling
    do_reset();
    run_stream(10, 1'b0, 300);

    // Randomized stream including illegal opcodes
    do_reset();
    run_stream(80, 1'b1, 3000);

    // Scenario 5: asynchronous reset while DRIVE with count=3
    do_reset();
    push_one(4'h3, 4'h3, 4'hF);
    push_one(4'h1, 4'h2, 4'h5);
    push_one(4'h3, 4'h4, 4'h6);
    push_one(4'h5, 4'h6, 4'h7);
    push_one(4'h7, 4'h8, 4'h8);
    out_ready = 1'b1;
    push_one(4'h9, 4'hA, 4'h9);
    out_ready = 1'b0;
    chk("t5_pre_count", count, 3);
    chk("t5_pre_alu_op", alu_op, 4'h6);
    chk("t5_pre_err", err_illegal, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_count", count, 0);
    chk("t5_rst_alu", {alu_op, alu_a, alu_b}, 0);
    chk("t5_rst_err", err_illegal, 0);
    chk("t5_rst_out", {out_op, out_res}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    err_m = 1'b0;
    push_one(4'h1, 4'h1, 4'hC);
    collect("t5", 8'hC0);
    tick();
    chk("t5_end_count", count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
